// File: rtl/fp32_sub_seq.sv
// Sequential FP32 subtractor (diff = a - b) with one-bit-per-cycle renormalisation.
// Optional feature macro: FP_SUB_ROUND_EN selects round-to-nearest-even (default build truncates).
module fp32_sub_seq #(
  parameter int WIDTH  = 32,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             flag_zero,
  output logic             flag_ovf,
  output logic             flag_unf
);
  localparam int MAN_W = FRAC_W + 4;

  typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d, diff_q, diff_d;
  logic               sign_q, sign_d, add_q, add_d;
  logic [EXP_W:0]     exp_q, exp_d;
  logic [MAN_W-1:0]   big_q, big_d, small_q, small_d;
  logic [MAN_W:0]     man_q, man_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;
  logic               out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic               sa, sb, a_ge, lost, complete, unused_bits;
  logic [EXP_W-1:0]   ea, eb, e_big, e_small, shamt;
  logic [FRAC_W-1:0]  fa, fb;
  logic [MAN_W-1:0]   m_big, m_small, m_aligned, fin_man;
  logic [EXP_W:0]     fin_exp;
  logic [FRAC_W-1:0]  res_frac;
`ifdef FP_SUB_ROUND_EN
  logic               round_up;
  logic [FRAC_W+1:0]  rnd_man;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign flag_zero = zero_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sign_d      = sign_q;
    add_d       = add_q;
    exp_d       = exp_q;
    big_d       = big_q;
    small_d     = small_q;
    man_d       = man_q;
    diff_d      = diff_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    complete    = 1'b0;
    fin_man     = '0;
    fin_exp     = '0;
    res_frac    = '0;
    unused_bits = 1'b0;
`ifdef FP_SUB_ROUND_EN
    round_up    = 1'b0;
    rnd_man     = '0;
`endif

    // Alignment datapath: denormals read as zero, larger magnitude becomes the "big" operand.
    sa        = opa_q[WIDTH-1];
    sb        = opb_q[WIDTH-1];
    ea        = opa_q[WIDTH-2 -: EXP_W];
    eb        = opb_q[WIDTH-2 -: EXP_W];
    fa        = (ea == '0) ? '0 : opa_q[FRAC_W-1:0];
    fb        = (eb == '0) ? '0 : opb_q[FRAC_W-1:0];
    a_ge      = {ea, fa} >= {eb, fb};
    e_big     = a_ge ? ea : eb;
    e_small   = a_ge ? eb : ea;
    m_big     = {(e_big != '0), (a_ge ? fa : fb), 3'b000};
    m_small   = {(e_small != '0), (a_ge ? fb : fa), 3'b000};
    shamt     = e_big - e_small;
    // Shift amounts of MAN_W or more clear the whole mask, so only the sticky bit survives.
    lost      = |(m_small & ~({MAN_W{1'b1}} << shamt));
    m_aligned = (m_small >> shamt) | {{(MAN_W-1){1'b0}}, lost};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d      = a;
          opb_d      = {~b[WIDTH-1], b[WIDTH-2:0]};
          zero_d     = 1'b0;
          ovf_d      = 1'b0;
          unf_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ALIGN;
        end
      end
      ALIGN: begin
        if (ea == '1 || eb == '1) begin
          if ((ea == '1 && opa_q[FRAC_W-1:0] != '0) || (eb == '1 && opb_q[FRAC_W-1:0] != '0) ||
              (ea == '1 && eb == '1 && sa != sb))
            diff_d = 32'h7FC0_0000;
          else if (ea == '1)
            diff_d = {sa, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          else
            diff_d = {sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          sign_d  = a_ge ? sa : sb;
          add_d   = (sa == sb);
          exp_d   = {1'b0, e_big};
          big_d   = m_big;
          small_d = m_aligned;
          state_d = SUB;
        end
      end
      SUB: begin
        man_d   = add_q ? ({1'b0, big_q} + {1'b0, small_q}) : ({1'b0, big_q} - {1'b0, small_q});
        state_d = NORM;
      end
      NORM: begin
        if (man_q[MAN_W]) begin
          fin_man  = man_q[MAN_W:1] | {{(MAN_W-1){1'b0}}, man_q[0]};
          fin_exp  = exp_q + 9'd1;
          complete = 1'b1;
        end else if (man_q == '0) begin
          diff_d      = '0;
          zero_d      = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (man_q[MAN_W-1]) begin
          fin_man  = man_q[MAN_W-1:0];
          fin_exp  = exp_q;
          complete = 1'b1;
        end else if (exp_q == 9'd1) begin
          diff_d      = '0;
          zero_d      = 1'b1;
          unf_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          man_d = man_q << 1;
          exp_d = exp_q - 9'd1;
        end

        if (complete) begin
`ifdef FP_SUB_ROUND_EN
          round_up = fin_man[2] & (fin_man[1] | fin_man[0] | fin_man[3]);
          rnd_man  = {1'b0, fin_man[MAN_W-1:3]} + {{(FRAC_W+1){1'b0}}, round_up};
          // A rounding carry leaves the fraction all-zero, so only the exponent moves.
          if (rnd_man[FRAC_W+1])
            fin_exp = fin_exp + 9'd1;
          res_frac    = rnd_man[FRAC_W-1:0];
          unused_bits = rnd_man[FRAC_W];
`else
          res_frac    = fin_man[MAN_W-2:3];
          unused_bits = ^{fin_man[MAN_W-1], fin_man[2:0]};
`endif
          if (fin_exp >= 9'd255) begin
            diff_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_d  = 1'b1;
          end else begin
            diff_d = {sign_q, fin_exp[EXP_W-1:0], res_frac};
          end
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      sign_q      <= 1'b0;
      add_q       <= 1'b0;
      exp_q       <= '0;
      big_q       <= '0;
      small_q     <= '0;
      man_q       <= '0;
      diff_q      <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sign_q      <= sign_d;
      add_q       <= add_d;
      exp_q       <= exp_d;
      big_q       <= big_d;
      small_q     <= small_d;
      man_q       <= man_d;
      diff_q      <= diff_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end
endmodule

// File: tb/tb_fp32_sub_seq.sv
// Self-checking bench for fp32_sub_seq: directed table, handshake/reset sequences,
// and randomized operands checked against an arithmetic reference model.
module tb_fp32_sub_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, flag_zero, flag_ovf, flag_unf;
  logic [31:0] diff;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [2:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  fp32_sub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .diff(diff),
    .flag_zero(flag_zero), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Reference: exact integer alignment with sticky, leading-one count, then pack.
  function automatic void refModel(input logic [31:0] ra, input logic [31:0] rb,
                                   output logic [31:0] d, output logic [2:0] flg, output int lat);
    logic   sa, sb, sr, ssm;
    int     ea, eb, e, esm, sh, p, lz;
    longint fa, fb, ka, kb, mbig, msm, al, r, mant, rem;
    logic [7:0] e8;
    logic [22:0] f23;
    sa = ra[31]; sb = ~rb[31];
    ea = int'(ra[30:23]); eb = int'(rb[30:23]);
    fa = longint'(ra[22:0]); fb = longint'(rb[22:0]);
    d = '0; flg = 3'b000; lat = 4;
    if (ea == 255 || eb == 255) begin
      lat = 2;
      if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) || (ea == 255 && eb == 255 && sa != sb))
        d = 32'h7FC00000;
      else if (ea == 255)
        d = {sa, 8'hFF, 23'h0};
      else
        d = {sb, 8'hFF, 23'h0};
      return;
    end
    if (ea == 0) fa = 0;
    if (eb == 0) fb = 0;
    ka = longint'(ea) * 64'd8388608 + fa;
    kb = longint'(eb) * 64'd8388608 + fb;
    if (ka >= kb) begin
      sr = sa; e = ea; mbig = (ea == 0) ? 0 : ((64'd8388608 + fa) * 8);
      ssm = sb; esm = eb; msm = (eb == 0) ? 0 : ((64'd8388608 + fb) * 8);
    end else begin
      sr = sb; e = eb; mbig = (eb == 0) ? 0 : ((64'd8388608 + fb) * 8);
      ssm = sa; esm = ea; msm = (ea == 0) ? 0 : ((64'd8388608 + fa) * 8);
    end
    sh = e - esm;
    if (sh >= 27) al = (msm != 0) ? 1 : 0;
    else begin
      al = msm >> sh;
      if ((msm % (64'd1 << sh)) != 0) al = al | 1;
    end
    r = (sr == ssm) ? mbig + al : mbig - al;
    if (r == 0) begin
      flg = 3'b100;
      return;
    end
    if (r >= (64'd1 << 27)) begin
      r = (r >> 1) | (r & 1);
      e = e + 1;
    end else begin
      p = 0;
      for (int i = 0; i < 27; i++) if (((r >> i) & 1) == 1) p = i;
      lz = 26 - p;
      if (lz >= e) begin
        flg = 3'b101;
        lat = 3 + e;
        return;
      end
      r = r << lz;
      e = e - lz;
      lat = 4 + lz;
    end
    mant = r >> 3;
`ifdef FP_SUB_ROUND_EN
    rem = r % 8;
    if (rem > 4 || (rem == 4 && (mant % 2) == 1)) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e = e + 1;
    end
`else
    rem = 0;
`endif
    if (e >= 255) begin
      d = {sr, 8'hFF, 23'h0};
      flg = 3'b010;
    end else begin
      e8 = 8'(e);
      f23 = 23'(mant);
      d = {sr, e8, f23};
    end
  endfunction

  task automatic startOp(input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c + 1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                               output logic [31:0] d, output logic [2:0] flg, output int lat);
    startOp(va, vb);
    waitValid(lat);
    d = diff;
    flg = {flag_zero, flag_ovf, flag_unf};
    if (lat > 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] d, ed, ra, rb;
    logic [2:0]  flg, eflg;
    int          lat, elat;
    logic        seen;

    vecs[0]  = '{32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 4};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 3'b100, 4};
    vecs[2]  = '{32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 3'b000, 28};
    vecs[3]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 3'b000, 4};
    vecs[4]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3'b010, 4};
    vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b000, 2};
    vecs[6]  = '{32'h3F800000, 32'h7FC00000, 32'h7FC00000, 3'b000, 2};
    vecs[7]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000, 2};
    vecs[8]  = '{32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000, 2};
    vecs[9]  = '{32'h00800001, 32'h00800000, 32'h00000000, 3'b101, 4};
    vecs[10] = '{32'h01000001, 32'h01000000, 32'h00000000, 3'b101, 5};
    vecs[11] = '{32'h00000005, 32'h3F800000, 32'hBF800000, 3'b000, 4};
    vecs[12] = '{32'h00000000, 32'h80000000, 32'h00000000, 3'b100, 4};
    vecs[13] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 3'b000, 5};
    vecs[14] = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 3'b000, 4};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_diff", diff, 32'd0);
    checkOutput("reset_flags", 32'({flag_zero, flag_ovf, flag_unf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, d, flg, lat);
      checkOutput($sformatf("vec%0d_diff", i), d, vecs[i].d);
      checkOutput($sformatf("vec%0d_flags", i), 32'(flg), 32'(vecs[i].flg));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result must be held while the consumer stalls.
    startOp(32'h40400000, 32'h3F800000);
    waitValid(lat);
    checkOutput("hold_latency", 32'(lat), 32'd4);
    for (int c = 0; c < 10; c++) begin
      checkOutput("hold_diff", diff, 32'h40000000);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of the long renormalisation must drop the operation.
    startOp(32'h3F800000, 32'h3F7FFFFF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("midreset_no_result", 32'(seen), 32'd0);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      ra[30:23] = 8'($urandom_range(1, 254));
      rb = $urandom;
      case (i % 4)
        0: rb[30:23] = 8'($urandom_range(1, 254));
        1: rb[30:23] = ra[30:23];
        2: rb = ra ^ (32'd1 << $urandom_range(0, 22)) ^ (32'($urandom_range(0, 1)) << 31);
        default: rb[30:23] = ra[30:23] - 8'($urandom_range(0, 3));
      endcase
      if (i % 37 == 0) rb[30:23] = 8'd0;
      if (i % 53 == 0) rb[30:23] = 8'd255;
      refModel(ra, rb, ed, eflg, elat);
      applyStimulus(ra, rb, d, flg, lat);
      checkOutput($sformatf("rand%0d_diff a=%h b=%h", i, ra, rb), d, ed);
      checkOutput($sformatf("rand%0d_flags", i), 32'(flg), 32'(eflg));
      checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(elat));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
